dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data cache controller between the pipeline memory stage and the banked main memory.
- Memory stage is the initiator: rd/wr/addr/wdata. This block is the responder: stall, done, data_out, plus the cache_req/cache_hit strobes the performance bench counts.
- Talks to main memory one word at a time through a stall/rvalid interface.

Parameters:
- IDX_BITS, 5, index width; cache holds 2**IDX_BITS lines of 4 words.
- MAX_OUTSTANDING, 4, maximum memory reads issued but not yet returned.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rd  in  1  read request from memory stage.
- wr  in  1  write request from memory stage.
- addr  in  16  byte address. addr[0]=byte offset, addr[2:1]=word, addr[IDX_BITS+2:3]=index, remaining upper bits=tag (8 bits at default).
- wdata  in  16  store data.
- data_out  out  16  load data, valid when done=1 and the access was a read.
- done  out  1  one-cycle pulse: access complete.
- stall  out  1  controller busy; new requests ignored.
- cache_req  out  1  one-cycle pulse when a request is accepted.
- cache_hit  out  1  asserted with done when the access hit on first lookup.
- err  out  1  asserted with done on an illegal request.
- mem_en  out  1  memory request valid.
- mem_wr  out  1  memory request is a write.
- mem_addr  out  16  word-aligned memory byte address.
- mem_wdata  out  16  memory write data.
- mem_stall  in  1  memory cannot accept a request this cycle.
- mem_rvalid  in  1  read data returning, in issue order.
- mem_rdata  in  16  returned read data.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - All valid and dirty bits cleared.
  - FSM returns to IDLE; issue and return counters cleared.
  - All outputs 0 from the next cycle.
  - Applies mid-fill or mid-writeback: the partial line is discarded, and mem_rvalid arriving after reset is ignored.
- IDLE:
  - A cycle with rd|wr and stall=0 is accepted: addr, wdata and op are registered, cache_req=1 that cycle, go to COMPARE.
  - rd&wr together, or addr[0]=1, is illegal: go to ERR instead (cache_req still 1).
- COMPARE (one cycle after acceptance), lookup on the registered index:
  - Hit (valid and tag match): done=1 and cache_hit=1 this cycle.
    - Read: data_out = the addressed word.
    - Write: the word is written and the line's dirty bit set.
    - Return to IDLE.
  - Miss, line clean or invalid: go to FILL.
  - Miss, line valid and dirty: go to WB.
- WB:
  - Issues 4 writes, words 0..3, address {old_tag, index, word, 1'b0}.
  - Each write is held until a cycle with mem_stall=0.
  - After the 4th accepted write, go to FILL.
- FILL:
  - Issues 4 reads, words 0..3, with the new tag; each read is held while mem_stall=1.
  - At most MAX_OUTSTANDING reads may be outstanding.
  - Returned words are stored in order by a 2-bit return counter.
  - After the 4th mem_rvalid: set valid, write the new tag, clear dirty; go to RETRY.
  - Issue and return may occur in the same cycle; both counters update.
- RETRY: behaves exactly like a COMPARE hit (store merges, dirty set), except cache_hit=0. done=1, then return to IDLE.
- ERR: done=1 and err=1 for one cycle; no array or memory access; return to IDLE.
- stall is 1 in every state except IDLE. It is combinationally 1 in the acceptance cycle only from the next cycle onward; it is never 1 in IDLE.
- Miss latency: 1 + (dirty ? 4 : 0) + 4 issues + memory latency + 1 cycles, minimum.
- mem_en=0 outside WB and FILL.
- mem_rvalid outside FILL is ignored.
- Tag and index widths are derived from IDX_BITS; no arithmetic overflow exists beyond the 2-bit word counters, which wrap 3 -> 0.

Decomposition:
- Shared package dcache_pkg holds:
  - FSM state encoding (IDLE, COMPARE, WB, FILL, RETRY, ERR).
  - WORDS_PER_LINE=4.
  - Address-field width and position functions of IDX_BITS.
- One sub-module, dcache_array, holds valid, dirty, tag and a 4-word data array per line. It has a combinational read port, one word-write port, and a line-install port. The FSM stays in dcache_ctrl.

Test Plan:
- Cold read: after reset, rd addr=0x0046 with memory preloaded 0x0040..0x0046 = 0x1111,0x2222,0x3333,0x4444 -> cache_req once, 4 mem reads to 0x0040/42/44/46, done with data_out=0x4444, cache_hit=0, err=0.
- Read hit: repeat rd 0x0042 -> done exactly 1 cycle after accept, data_out=0x2222, cache_hit=1, mem_en never asserted.
- Dirty eviction: wr 0x0040 wdata=0xBEEF (hit), then rd 0x1040 (same index, different tag) -> 4 writes issued first, word0 at 0x0040 = 0xBEEF, then 4 reads from 0x1040..0x1046, done with cache_hit=0.
- Backpressure: mem_stall=1 for 3 cycles during FILL -> mem_addr and mem_en held stable, no duplicate issue, same returned data.
- Illegal requests: rd&wr at 0x0010, then rd 0x0011 -> each gives done=1, err=1, one cycle after accept, no memory traffic.
- Reset mid-fill: rst asserted after 2 reads issued, late mem_rvalid pulses follow -> outputs 0, next rd 0x0040 misses (cache_hit=0) and refills correctly.

Source files
------------

// File: rtl/dcache_pkg.sv
// ---------------------------------------------------------------------------
// dcache_pkg -- shared types and address-field helpers for the data cache
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dcache_pkg;

  localparam int WORDS_PER_LINE = 4;
  localparam int ADDR_W         = 16;
  localparam int DATA_W         = 16;
  localparam int IDX_LSB        = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COMPARE = 3'd1,
    S_WB      = 3'd2,
    S_FILL    = 3'd3,
    S_RETRY   = 3'd4,
    S_ERR     = 3'd5
  } state_e;

  typedef logic [WORDS_PER_LINE-1:0][DATA_W-1:0] line_t;

  function automatic int tag_lsb(input int idx_bits);
    return IDX_LSB + idx_bits;
  endfunction

  function automatic int tag_bits(input int idx_bits);
    return ADDR_W - tag_lsb(idx_bits);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_ctrl_if.sv
// ---------------------------------------------------------------------------
// dcache_ctrl_if -- memory-stage request bus plus main-memory word port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface dcache_ctrl_if;
  import dcache_pkg::*;

  logic              rd;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] data_out;
  logic              done;
  logic              stall;
  logic              cache_req;
  logic              cache_hit;
  logic              err;
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_stall;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output rd, wr, addr, wdata, mem_stall, mem_rvalid, mem_rdata,
    input  data_out, done, stall, cache_req, cache_hit, err,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

  modport slave (
    input  rd, wr, addr, wdata, mem_stall, mem_rvalid, mem_rdata,
    output data_out, done, stall, cache_req, cache_hit, err,
           mem_en, mem_wr, mem_addr, mem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/dcache_array.sv
// ---------------------------------------------------------------------------
// dcache_array -- valid/dirty/tag/data storage, async read, word + line write
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dcache_array
  import dcache_pkg::*;
#(
  parameter int IDX_BITS = 5,
  parameter int TAG_W    = 8
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic [IDX_BITS-1:0] idx_i,
  output logic                     valid_o,
  output logic                     dirty_o,
  output logic [TAG_W-1:0]         tag_o,
  output line_t                    line_o,
  input  wire logic                wr_en_i,
  input  wire logic [1:0]          wr_word_i,
  input  wire logic [DATA_W-1:0]   wr_data_i,
  input  wire logic                inst_en_i,
  input  wire logic [TAG_W-1:0]    inst_tag_i,
  input  wire line_t               inst_data_i
);

  localparam int NLINES = 2 ** IDX_BITS;

  logic [NLINES-1:0] valid_q;
  logic [NLINES-1:0] dirty_q;
  logic [TAG_W-1:0]  tag_q  [NLINES];
  line_t             data_q [NLINES];

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (inst_en_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (wr_en_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // Tag and data need no reset: a line is only read once its valid bit is set.
  always_ff @(posedge clk) begin
    if (inst_en_i) begin
      tag_q[idx_i]  <= inst_tag_i;
      data_q[idx_i] <= inst_data_i;
    end else if (wr_en_i) begin
      data_q[idx_i][wr_word_i] <= wr_data_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dcache_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_ctrl -- direct-mapped write-back write-allocate data cache controller
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int IDX_BITS        = 5,
  parameter int MAX_OUTSTANDING = 4
) (
  input wire logic    clk,
  input wire logic    rst,
  dcache_ctrl_if.slave bus
);

  localparam int         TAG_W      = tag_bits(IDX_BITS);
  localparam int         TAG_LSB    = tag_lsb(IDX_BITS);
  localparam logic [3:0] c_max_out  = 4'(MAX_OUTSTANDING);

  state_e              state_q;
  logic [ADDR_W-1:1]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                wr_q;
  logic [1:0]          wb_q;
  logic [2:0]          iss_q;
  logic [2:0]          ret_q;
  logic [DATA_W-1:0]   buf_q [3];

  logic                arr_valid;
  logic                arr_dirty;
  logic [TAG_W-1:0]    arr_tag;
  line_t               arr_line;

  logic [TAG_W-1:0]    w_tag;
  logic [IDX_BITS-1:0] w_idx;
  logic [1:0]          w_word;
  logic                w_hit;
  logic                w_lookup;
  logic [2:0]          w_out;
  logic                w_issue;
  logic                w_ret;
  logic                w_inst;

  assign w_tag    = addr_q[ADDR_W-1:TAG_LSB];
  assign w_idx    = addr_q[TAG_LSB-1:IDX_LSB];
  assign w_word   = addr_q[2:1];
  assign w_hit    = arr_valid && (arr_tag == w_tag);
  assign w_lookup = ((state_q == S_COMPARE) && w_hit) || (state_q == S_RETRY);
  assign w_out    = iss_q - ret_q;
  assign w_issue  = (state_q == S_FILL) && (iss_q != 3'd4) && ({1'b0, w_out} < c_max_out);
  // Returns with nothing outstanding are stale and dropped.
  assign w_ret    = (state_q == S_FILL) && bus.mem_rvalid && (ret_q != iss_q);
  assign w_inst   = w_ret && (ret_q[1:0] == 2'd3);

  dcache_array #(
    .IDX_BITS (IDX_BITS),
    .TAG_W    (TAG_W)
  ) u_array (
    .clk         (clk),
    .rst         (rst),
    .idx_i       (w_idx),
    .valid_o     (arr_valid),
    .dirty_o     (arr_dirty),
    .tag_o       (arr_tag),
    .line_o      (arr_line),
    .wr_en_i     (w_lookup && wr_q),
    .wr_word_i   (w_word),
    .wr_data_i   (wdata_q),
    .inst_en_i   (w_inst),
    .inst_tag_i  (w_tag),
    .inst_data_i ({bus.mem_rdata, buf_q[2], buf_q[1], buf_q[0]})
  );

  always_comb begin
    bus.stall     = (state_q != S_IDLE);
    bus.cache_req = (state_q == S_IDLE) && (bus.rd || bus.wr);
    bus.done      = w_lookup || (state_q == S_ERR);
    bus.cache_hit = (state_q == S_COMPARE) && w_hit;
    bus.err       = (state_q == S_ERR);
    bus.data_out  = (w_lookup && !wr_q) ? arr_line[w_word] : '0;
    bus.mem_en    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (state_q == S_WB) begin
      bus.mem_en    = 1'b1;
      bus.mem_wr    = 1'b1;
      bus.mem_addr  = {arr_tag, w_idx, wb_q, 1'b0};
      bus.mem_wdata = arr_line[wb_q];
    end else if (w_issue) begin
      bus.mem_en    = 1'b1;
      bus.mem_addr  = {w_tag, w_idx, iss_q[1:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      wb_q    <= '0;
      iss_q   <= '0;
      ret_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.rd || bus.wr) begin
            addr_q  <= bus.addr[ADDR_W-1:1];
            wdata_q <= bus.wdata;
            wr_q    <= bus.wr;
            state_q <= ((bus.rd && bus.wr) || bus.addr[0]) ? S_ERR : S_COMPARE;
          end
        end
        S_COMPARE: begin
          if (!w_hit) begin
            wb_q    <= '0;
            iss_q   <= '0;
            ret_q   <= '0;
            state_q <= (arr_valid && arr_dirty) ? S_WB : S_FILL;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WB: begin
          if (!bus.mem_stall) begin
            wb_q <= wb_q + 2'd1;
            if (wb_q == 2'd3) state_q <= S_FILL;
          end
        end
        S_FILL: begin
          if (w_issue && !bus.mem_stall) iss_q <= iss_q + 3'd1;
          if (w_ret) begin
            ret_q <= ret_q + 3'd1;
            if (w_inst) state_q <= S_RETRY;
            else        buf_q[ret_q[1:0]] <= bus.mem_rdata;
          end
        end
        S_RETRY, S_ERR: state_q <= S_IDLE;
        default:        state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dcache_ctrl -- directed self-checking bench with a 2-cycle memory model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dcache_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dcache_ctrl_if bus();

  dcache_ctrl #(
    .IDX_BITS        (5),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  // Memory model: accepts on mem_en && !mem_stall, returns reads 2 cycles later.
  typedef struct packed {logic w; logic [15:0] a; logic [15:0] d;} txn_t;
  typedef struct packed {logic [15:0] d; int t;} rd_t;

  logic [15:0] mem [32768];
  txn_t        lg[$];
  rd_t         rq[$];
  int          cyc          = 0;
  int          en_cycles    = 0;
  int          hold_viol    = 0;
  int          rd_total     = 0;
  int          stall_after  = 0;
  int          stall_budget = 0;
  logic        prev_stalled = 1'b0;
  logic [15:0] prev_addr    = '0;

  always @(negedge clk) begin
    rd_t  r;
    txn_t t;
    cyc++;
    if (rq.size() > 0 && rq[0].t <= cyc) begin
      r = rq.pop_front();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = r.d;
    end else begin
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = '0;
    end
    bus.mem_stall = 1'b0;
    if (bus.mem_en && !bus.mem_wr && stall_budget > 0 && rd_total > stall_after) begin
      bus.mem_stall = 1'b1;
      stall_budget--;
    end
    if (prev_stalled && (!bus.mem_en || bus.mem_addr != prev_addr)) hold_viol++;
    prev_stalled = bus.mem_en && bus.mem_stall;
    prev_addr    = bus.mem_addr;
    if (bus.mem_en) en_cycles++;
    if (bus.mem_en && !bus.mem_stall) begin
      t.w = bus.mem_wr;
      t.a = bus.mem_addr;
      t.d = bus.mem_wr ? bus.mem_wdata : mem[bus.mem_addr[15:1]];
      lg.push_back(t);
      if (bus.mem_wr) mem[bus.mem_addr[15:1]] = bus.mem_wdata;
      else begin
        rd_total++;
        r.d = mem[bus.mem_addr[15:1]];
        r.t = cyc + 2;
        rq.push_back(r);
      end
    end
  end

  logic        r_done;
  logic [15:0] r_data;
  logic        r_hit;
  logic        r_err;
  int          r_lat;
  int          r_req;

  task automatic access(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    bus.rd = r; bus.wr = w; bus.addr = a; bus.wdata = d;
    @(negedge clk);
    r_req = int'(bus.cache_req);
    @(posedge clk); #1;
    bus.rd = 1'b0; bus.wr = 1'b0;
    r_done = 1'b0; r_lat = 0; r_data = '0; r_hit = 1'b0; r_err = 1'b0;
    for (int i = 0; i < 200 && !r_done; i++) begin
      @(negedge clk);
      r_lat++;
      r_req += int'(bus.cache_req);
      if (bus.done) begin
        r_done = 1'b1;
        r_data = bus.data_out;
        r_hit  = bus.cache_hit;
        r_err  = bus.err;
      end
    end
  endtask

  function automatic logic [31:0] outs_now();
    return {bus.data_out, 6'd0, bus.stall, bus.done, bus.err, bus.cache_hit,
            bus.cache_req, bus.mem_en, bus.mem_wr, |bus.mem_addr, |bus.mem_wdata, 1'b0};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  int          base;
  int          en0;
  int          hv0;
  logic [31:0] acc;

  initial begin
    bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
    bus.mem_stall = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'(i) ^ 16'hFFFF;
    mem['h020] = 16'h1111; mem['h021] = 16'h2222; mem['h022] = 16'h3333; mem['h023] = 16'h4444;
    mem['h820] = 16'hA000; mem['h821] = 16'hA001; mem['h822] = 16'hA002; mem['h823] = 16'hA003;
    mem['h044] = 16'hC000; mem['h045] = 16'hC001; mem['h046] = 16'hC002; mem['h047] = 16'hC003;
    mem['h048] = 16'hD000; mem['h049] = 16'hD001; mem['h04A] = 16'hD002; mem['h04B] = 16'hD003;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_outs", outs_now(), 32'h0);

    // Cold read miss on a clean line.
    base = lg.size();
    access(1'b1, 1'b0, 16'h0046, 16'h0);
    check("cold_done", r_done, 1);
    check("cold_req", r_req, 1);
    check("cold_data", r_data, 16'h4444);
    check("cold_hit_err", {r_hit, r_err}, 2'b00);
    check("cold_lat", r_lat, 8);
    check("cold_nmem", lg.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (lg.size() > base + i)
        check("cold_rd_addr", {lg[base+i].w, lg[base+i].a}, {1'b0, 16'h0040 + 16'(2*i)});

    // Read hit.
    en0 = en_cycles;
    access(1'b1, 1'b0, 16'h0042, 16'h0);
    check("hit_lat", r_lat, 1);
    check("hit_data", r_data, 16'h2222);
    check("hit_flag", r_hit, 1);
    check("hit_no_mem", en_cycles - en0, 0);

    // Write hit, then dirty eviction by a conflicting tag.
    access(1'b0, 1'b1, 16'h0040, 16'hBEEF);
    check("whit_flag_lat", {r_hit, 8'(r_lat)}, {1'b1, 8'd1});
    base = lg.size();
    access(1'b1, 1'b0, 16'h1040, 16'h0);
    check("evict_nmem", lg.size() - base, 8);
    for (int i = 0; i < 4; i++)
      if (lg.size() > base + i) begin
        check("wb_addr", {lg[base+i].w, lg[base+i].a}, {1'b1, 16'h0040 + 16'(2*i)});
        check("wb_data", lg[base+i].d, (i == 0) ? 16'hBEEF : 16'h1111 * 16'(i + 1));
      end
    for (int i = 4; i < 8; i++)
      if (lg.size() > base + i)
        check("evict_rd_addr", {lg[base+i].w, lg[base+i].a}, {1'b0, 16'h1040 + 16'(2*(i-4))});
    check("evict_mem", mem['h020], 16'hBEEF);
    check("evict_data", r_data, 16'hA000);
    check("evict_hit", r_hit, 0);

    // Backpressure: three stalled cycles after the first fill read.
    base = lg.size();
    hv0  = hold_viol;
    stall_after  = rd_total;
    stall_budget = 3;
    access(1'b1, 1'b0, 16'h008C, 16'h0);
    check("bp_stalls_used", stall_budget, 0);
    check("bp_hold", hold_viol - hv0, 0);
    check("bp_nmem", lg.size() - base, 4);
    for (int i = 0; i < 4; i++)
      if (lg.size() > base + i)
        check("bp_addr", {lg[base+i].w, lg[base+i].a}, {1'b0, 16'h0088 + 16'(2*i)});
    check("bp_data", r_data, 16'hC002);

    // Write miss allocates and merges the store.
    access(1'b0, 1'b1, 16'h0090, 16'h1234);
    check("wmiss_done_hit", {r_done, r_hit}, 2'b10);
    access(1'b1, 1'b0, 16'h0090, 16'h0);
    check("wmiss_merged", {r_hit, r_data}, {1'b1, 16'h1234});
    access(1'b1, 1'b0, 16'h0092, 16'h0);
    check("wmiss_neighbour", {r_hit, r_data}, {1'b1, 16'hD001});

    // Illegal requests.
    en0 = en_cycles;
    access(1'b1, 1'b1, 16'h0010, 16'h0);
    check("ill_rdwr", {r_done, r_err, r_hit, 8'(r_lat), r_req[3:0]}, {3'b110, 8'd1, 4'd1});
    access(1'b1, 1'b0, 16'h0011, 16'h0);
    check("ill_odd", {r_done, r_err, r_hit, 8'(r_lat), r_data}, {3'b110, 8'd1, 16'h0});
    check("ill_no_mem", en_cycles - en0, 0);

    // Reset in the middle of a fill, with late returns arriving afterwards.
    base = lg.size();
    @(posedge clk); #1;
    bus.rd = 1'b1; bus.addr = 16'h0040;
    @(posedge clk); #1;
    bus.rd = 1'b0;
    for (int i = 0; i < 50 && lg.size() < base + 2; i++) @(negedge clk);
    check("rst_two_issued", (lg.size() >= base + 2), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    acc = '0;
    repeat (5) begin
      @(negedge clk);
      acc = acc | outs_now();
    end
    check("rst_outs_zero", acc, 32'h0);
    access(1'b1, 1'b0, 16'h0040, 16'h0);
    check("rst_refill", {r_done, r_hit, r_data}, {2'b10, 16'hBEEF});
    access(1'b1, 1'b0, 16'h0046, 16'h0);
    check("rst_refill_hit", {r_hit, r_data}, {1'b1, 16'h4444});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
